mt9v_clock_align_seq: RTL and testbench

- Multi-channel reset-sequencing and clock-pattern alignment controller for the MT9V034 LVDS deserializer.
- Runs in the deserializer divided-clock domain, downstream of the MMCM/BUFIO clock infrastructure.
- Sequences I/O reset and enable after MMCM lock. Then, per channel, bit-slips the ISERDES until the forwarded-clock word matches the training pattern.
- Supervises alignment continuously and re-trains any channel that loses it.

---
 rtl/mt9v_deser_pkg.sv | 33 +++
 rtl/mt9v_chan_aligner.sv | 169 ++++++++++++++++
 rtl/mt9v_clock_align_seq.sv | 158 +++++++++++++++
 tb/tb_mt9v_clock_align_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt9v_deser_pkg.sv
// Shared encodings, bounds and helpers for the MT9V034 deserializer alignment logic.
package mt9v_deser_pkg;

  // Top-level sequencer states.
  localparam logic [1:0] TOP_WAIT_LOCK = 2'd0;
  localparam logic [1:0] TOP_RST       = 2'd1;
  localparam logic [1:0] TOP_ENA       = 2'd2;
  localparam logic [1:0] TOP_ALIGN     = 2'd3;

  // Per-channel alignment states.
  localparam logic [2:0] CH_IDLE   = 3'd0;
  localparam logic [2:0] CH_CHECK  = 3'd1;
  localparam logic [2:0] CH_VERIFY = 3'd2;
  localparam logic [2:0] CH_SLIP   = 3'd3;
  localparam logic [2:0] CH_WAIT   = 3'd4;
  localparam logic [2:0] CH_LOCKED = 3'd5;
  localparam logic [2:0] CH_FAIL   = 3'd6;

  // Legal parameter ranges.
  localparam int C_MIN_CHANNELS   = 1;
  localparam int C_MAX_CHANNELS   = 8;
  localparam int C_MIN_DATA_WIDTH = 4;
  localparam int C_MAX_DATA_WIDTH = 8;

  // Forwarded-clock training word for a 4-bit ISERDES.
  localparam logic [3:0] C_DEFAULT_CLOCK_PATTERN = 4'b1010;

  // Width of a counter that must reach 'limit' without wrapping.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/mt9v_chan_aligner.sv
// One deserializer channel: bit-slips until the clock word matches, then supervises lock.
module mt9v_chan_aligner
  import mt9v_deser_pkg::*;
#(
  parameter int                W            = 4,
  parameter logic [W-1:0]      PATTERN      = W'(C_DEFAULT_CLOCK_PATTERN),
  parameter int                MAX_SLIPS    = 4,
  parameter int                BITSLIP_WAIT = 3,
  parameter int                MATCH_COUNT  = 4,
  parameter int                LOSS_COUNT   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         start,
  input  logic         retrain,
  input  logic [W-1:0] word,
  output logic         bitslip,
  output logic         aligned,
  output logic         chan_error
);

  localparam int SW = cnt_width(MAX_SLIPS);
  localparam int WW = cnt_width(BITSLIP_WAIT);
  localparam int MW = cnt_width(MATCH_COUNT);
  localparam int LW = cnt_width(LOSS_COUNT);

  localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIPS);
  localparam logic [WW-1:0] WAIT_LAST  = WW'((BITSLIP_WAIT > 0) ? BITSLIP_WAIT - 1 : 0);
  localparam logic [MW-1:0] MATCH_LAST = MW'((MATCH_COUNT > 0) ? MATCH_COUNT - 1 : 0);
  localparam logic [LW-1:0] LOSS_LAST  = LW'((LOSS_COUNT > 0) ? LOSS_COUNT - 1 : 0);
  localparam logic [WW-1:0] WAIT_SAT   = {WW{1'b1}};
  localparam logic [MW-1:0] MATCH_SAT  = {MW{1'b1}};
  localparam logic [LW-1:0] LOSS_SAT   = {LW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] slip_cnt_q, slip_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [LW-1:0] loss_cnt_q, loss_cnt_d;
  logic          bitslip_q, bitslip_d;
  logic          aligned_q, aligned_d;
  logic          error_q, error_d;
  logic          match_s;

  assign match_s = (word == PATTERN);

  // Next-state logic: lock loss beats retrain, which beats normal alignment flow.
  always_comb begin
    state_d     = state_q;
    slip_cnt_d  = slip_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    match_cnt_d = match_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    bitslip_d   = 1'b0;
    aligned_d   = aligned_q;
    error_d     = error_q;
    if (clear || retrain) begin
      state_d     = clear ? CH_IDLE : CH_CHECK;
      slip_cnt_d  = {SW{1'b0}};
      wait_cnt_d  = {WW{1'b0}};
      match_cnt_d = {MW{1'b0}};
      loss_cnt_d  = {LW{1'b0}};
      aligned_d   = 1'b0;
      error_d     = 1'b0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (start) begin
            state_d     = CH_CHECK;
            slip_cnt_d  = {SW{1'b0}};
            match_cnt_d = {MW{1'b0}};
            loss_cnt_d  = {LW{1'b0}};
          end else begin
            state_d = CH_IDLE;
          end
        end
        CH_CHECK, CH_VERIFY: begin
          if (match_s) begin
            if (state_q == CH_CHECK) begin
              match_cnt_d = MW'(1);
            end else begin
              match_cnt_d = (match_cnt_q == MATCH_SAT) ? match_cnt_q : match_cnt_q + 1'b1;
            end
            // CHECK counts as the first match; VERIFY completes the run.
            if ((state_q == CH_VERIFY && match_cnt_q >= MATCH_LAST) ||
                (state_q == CH_CHECK && MATCH_LAST == {MW{1'b0}})) begin
              state_d    = CH_LOCKED;
              aligned_d  = 1'b1;
              loss_cnt_d = {LW{1'b0}};
            end else begin
              state_d = CH_VERIFY;
            end
          end else begin
            match_cnt_d = {MW{1'b0}};
            if (slip_cnt_q < SLIP_MAX) begin
              state_d   = CH_SLIP;
              bitslip_d = 1'b1;
            end else begin
              state_d   = CH_FAIL;
              error_d   = 1'b1;
              aligned_d = 1'b0;
            end
          end
        end
        CH_SLIP: begin
          slip_cnt_d = (slip_cnt_q == SLIP_MAX) ? slip_cnt_q : slip_cnt_q + 1'b1;
          wait_cnt_d = {WW{1'b0}};
          state_d    = CH_WAIT;
        end
        CH_WAIT: begin
          if (wait_cnt_q >= WAIT_LAST) begin
            state_d = CH_CHECK;
          end else begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
          end
        end
        CH_LOCKED: begin
          if (match_s) begin
            loss_cnt_d = {LW{1'b0}};
          end else if (loss_cnt_q >= LOSS_LAST) begin
            state_d     = CH_CHECK;
            aligned_d   = 1'b0;
            slip_cnt_d  = {SW{1'b0}};
            match_cnt_d = {MW{1'b0}};
            loss_cnt_d  = {LW{1'b0}};
          end else begin
            loss_cnt_d = (loss_cnt_q == LOSS_SAT) ? loss_cnt_q : loss_cnt_q + 1'b1;
          end
        end
        CH_FAIL: begin
          aligned_d = 1'b0;
          error_d   = 1'b1;
        end
        default: begin
          state_d = CH_IDLE;
        end
      endcase
    end
  end

  // Channel state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CH_IDLE;
      slip_cnt_q  <= {SW{1'b0}};
      wait_cnt_q  <= {WW{1'b0}};
      match_cnt_q <= {MW{1'b0}};
      loss_cnt_q  <= {LW{1'b0}};
      bitslip_q   <= 1'b0;
      aligned_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slip_cnt_q  <= slip_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      match_cnt_q <= match_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      bitslip_q   <= bitslip_d;
      aligned_q   <= aligned_d;
      error_q     <= error_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign chan_error = error_q;

endmodule

// File: rtl/mt9v_clock_align_seq.sv
// MT9V034 deserializer reset/enable sequencer and per-channel clock-pattern alignment.
module mt9v_clock_align_seq
  import mt9v_deser_pkg::*;
#(
  parameter int                            C_Channels        = 2,
  parameter int                            C_IoSrdsDataWidth = 4,
  parameter logic [C_IoSrdsDataWidth-1:0]  C_ClockPattern    = C_IoSrdsDataWidth'(C_DEFAULT_CLOCK_PATTERN),
  parameter int                            C_RstOutDly       = 2,
  parameter int                            C_EnaOutDly       = 6,
  parameter int                            C_MaxSlips        = 4,
  parameter int                            C_BitslipWait     = 3,
  parameter int                            C_MatchCount      = 4,
  parameter int                            C_LossCount       = 3
) (
  input  logic                                      ClkIn,
  input  logic                                      RstN,
  input  logic                                      MmcmLocked,
  input  logic                                      Retrain,
  input  logic [C_Channels*C_IoSrdsDataWidth-1:0]   SerdesData,
  output logic                                      IoRst,
  output logic                                      IoEna,
  output logic [C_Channels-1:0]                     Bitslip,
  output logic [C_Channels-1:0]                     Aligned,
  output logic                                      AllAligned,
  output logic [C_Channels-1:0]                     ChanError
);

  if (C_Channels < C_MIN_CHANNELS || C_Channels > C_MAX_CHANNELS ||
      C_IoSrdsDataWidth < C_MIN_DATA_WIDTH || C_IoSrdsDataWidth > C_MAX_DATA_WIDTH) begin : g_bad_param
    $error("mt9v_clock_align_seq: channel count or data width out of range");
  end

  localparam int TW = cnt_width((C_RstOutDly > C_EnaOutDly) ? C_RstOutDly : C_EnaOutDly);
  localparam logic [TW-1:0] RST_LAST = TW'((C_RstOutDly > 0) ? C_RstOutDly - 1 : 0);
  localparam logic [TW-1:0] ENA_LAST = TW'((C_EnaOutDly > 0) ? C_EnaOutDly - 1 : 0);
  localparam logic [TW-1:0] CNT_SAT  = {TW{1'b1}};

  logic            lock_meta_q, lock_sync_q;
  logic [1:0]      top_state_q, top_state_d;
  logic [TW-1:0]   top_cnt_q, top_cnt_d;
  logic            io_rst_q, io_rst_d;
  logic            io_ena_q, io_ena_d;
  logic            all_aligned_q;
  logic            chan_clear_s, chan_start_s, chan_retrain_s;
  logic [C_Channels-1:0] aligned_s;

  // Two-flop synchroniser for the asynchronous MMCM lock.
  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= MmcmLocked;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Sequencer: lock -> hold IoRst -> wait -> enable -> align; lock loss restarts it.
  always_comb begin
    top_state_d = top_state_q;
    top_cnt_d   = top_cnt_q;
    io_rst_d    = io_rst_q;
    io_ena_d    = io_ena_q;
    if (!lock_sync_q) begin
      top_state_d = TOP_WAIT_LOCK;
      top_cnt_d   = {TW{1'b0}};
      io_rst_d    = 1'b1;
      io_ena_d    = 1'b0;
    end else begin
      case (top_state_q)
        TOP_WAIT_LOCK: begin
          top_state_d = TOP_RST;
          top_cnt_d   = {TW{1'b0}};
          io_rst_d    = 1'b1;
        end
        TOP_RST: begin
          if (top_cnt_q >= RST_LAST) begin
            top_state_d = TOP_ENA;
            top_cnt_d   = {TW{1'b0}};
            io_rst_d    = 1'b0;
          end else begin
            top_cnt_d = (top_cnt_q == CNT_SAT) ? top_cnt_q : top_cnt_q + 1'b1;
          end
        end
        TOP_ENA: begin
          if (top_cnt_q >= ENA_LAST) begin
            top_state_d = TOP_ALIGN;
            top_cnt_d   = {TW{1'b0}};
            io_ena_d    = 1'b1;
          end else begin
            top_cnt_d = (top_cnt_q == CNT_SAT) ? top_cnt_q : top_cnt_q + 1'b1;
          end
        end
        TOP_ALIGN: begin
          top_state_d = TOP_ALIGN;
        end
        default: begin
          top_state_d = TOP_WAIT_LOCK;
        end
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      top_state_q <= TOP_WAIT_LOCK;
      top_cnt_q   <= {TW{1'b0}};
      io_rst_q    <= 1'b1;
      io_ena_q    <= 1'b0;
    end else begin
      top_state_q <= top_state_d;
      top_cnt_q   <= top_cnt_d;
      io_rst_q    <= io_rst_d;
      io_ena_q    <= io_ena_d;
    end
  end

  assign chan_clear_s   = ~lock_sync_q;
  assign chan_start_s   = (top_state_q == TOP_ALIGN);
  assign chan_retrain_s = Retrain & lock_sync_q & (top_state_q == TOP_ALIGN);

  for (genvar g = 0; g < C_Channels; g++) begin : g_chan
    mt9v_chan_aligner #(
      .W            (C_IoSrdsDataWidth),
      .PATTERN      (C_ClockPattern),
      .MAX_SLIPS    (C_MaxSlips),
      .BITSLIP_WAIT (C_BitslipWait),
      .MATCH_COUNT  (C_MatchCount),
      .LOSS_COUNT   (C_LossCount)
    ) u_chan (
      .clk        (ClkIn),
      .rst_n      (RstN),
      .clear      (chan_clear_s),
      .start      (chan_start_s),
      .retrain    (chan_retrain_s),
      .word       (SerdesData[g*C_IoSrdsDataWidth +: C_IoSrdsDataWidth]),
      .bitslip    (Bitslip[g]),
      .aligned    (aligned_s[g]),
      .chan_error (ChanError[g])
    );
  end

  // AllAligned trails the per-channel Aligned flags by one cycle.
  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      all_aligned_q <= 1'b0;
    end else begin
      all_aligned_q <= &aligned_s;
    end
  end

  assign Aligned    = aligned_s;
  assign AllAligned = all_aligned_q;
  assign IoRst      = io_rst_q;
  assign IoEna      = io_ena_q;

endmodule

// File: tb/tb_mt9v_clock_align_seq.sv
// Directed bench for mt9v_clock_align_seq with default parameters (2 channels, 4-bit words).
module tb_mt9v_clock_align_seq;

  logic       ClkIn = 1'b0;
  logic       RstN;
  logic       MmcmLocked;
  logic       Retrain;
  logic [7:0] SerdesData;
  logic       IoRst;
  logic       IoEna;
  logic [1:0] Bitslip;
  logic [1:0] Aligned;
  logic       AllAligned;
  logic [1:0] ChanError;

  int checks = 0;
  int errors = 0;

  mt9v_clock_align_seq dut (
    .ClkIn      (ClkIn),
    .RstN       (RstN),
    .MmcmLocked (MmcmLocked),
    .Retrain    (Retrain),
    .SerdesData (SerdesData),
    .IoRst      (IoRst),
    .IoEna      (IoEna),
    .Bitslip    (Bitslip),
    .Aligned    (Aligned),
    .AllAligned (AllAligned),
    .ChanError  (ChanError)
  );

  always #5 ClkIn = ~ClkIn;

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge ClkIn);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    RstN = 1'b0; MmcmLocked = 1'b0; Retrain = 1'b0;
    SerdesData = {4'b0101, 4'b1010};
    repeat (3) @(posedge ClkIn);
    #1;
    obs = {IoRst, IoEna, Bitslip, Aligned, ChanError, AllAligned};
    checks++;
    if (obs !== 9'b1_0_00_00_00_0) begin
      errors++; $display("FAIL reset_values: got %b expected %b", obs, 9'b1_0_00_00_00_0);
    end
    RstN = 1'b1;
    tick(); tick();
    checks++;
    if (IoRst !== 1'b1 || IoEna !== 1'b0) begin
      errors++; $display("FAIL no_lock_hold: got IoRst=%b IoEna=%b expected 1 0", IoRst, IoEna);
    end
  endtask

  task automatic test_lock_seq();
    int rst_fall = 0;
    int ena_rise = 0;
    bit slip_seen = 1'b0;
    MmcmLocked = 1'b1;
    for (int c = 1; c <= 30 && ena_rise == 0; c++) begin
      tick();
      if (IoRst === 1'b0 && rst_fall == 0) rst_fall = c;
      if (IoEna === 1'b1 && ena_rise == 0) ena_rise = c;
      if (Bitslip !== 2'b00) slip_seen = 1'b1;
    end
    checks++;
    if (rst_fall != 5) begin
      errors++; $display("FAIL iorst_fall_cycle: got %0d expected 5", rst_fall);
    end
    checks++;
    if (ena_rise != 11) begin
      errors++; $display("FAIL ioena_rise_cycle: got %0d expected 11", ena_rise);
    end
    checks++;
    if (slip_seen !== 1'b0) begin
      errors++; $display("FAIL bitslip_before_ena: got %b expected 0", slip_seen);
    end
  endtask

  // ch0 matches at once; ch1 presents 0101 until it has seen two Bitslip pulses.
  task automatic test_two_channels();
    int p0 = 0, p1 = 0, first_p1 = 0, last_p1 = 0, min_gap = 1000;
    int a0 = 0, a1 = 0, aa = 0;
    for (int c = 12; c <= 45; c++) begin
      tick();
      if (Bitslip[0] === 1'b1) p0++;
      if (Bitslip[1] === 1'b1) begin
        p1++;
        if (first_p1 == 0) first_p1 = c;
        if (last_p1 != 0 && (c - last_p1) < min_gap) min_gap = c - last_p1;
        last_p1 = c;
        if (p1 == 2) SerdesData[7:4] = 4'b1010;
      end
      if (Aligned[0] === 1'b1 && a0 == 0) a0 = c;
      if (Aligned[1] === 1'b1 && a1 == 0) a1 = c;
      if (AllAligned === 1'b1 && aa == 0) aa = c;
    end
    checks++;
    if (p0 != 0) begin errors++; $display("FAIL ch0_pulses: got %0d expected 0", p0); end
    checks++;
    if (a0 != 16) begin errors++; $display("FAIL ch0_aligned_cycle: got %0d expected 16", a0); end
    checks++;
    if (p1 != 2) begin errors++; $display("FAIL ch1_pulses: got %0d expected 2", p1); end
    checks++;
    if (first_p1 != 13) begin errors++; $display("FAIL ch1_first_pulse: got %0d expected 13", first_p1); end
    checks++;
    if (min_gap < 4) begin errors++; $display("FAIL ch1_pulse_gap: got %0d expected >=4", min_gap); end
    checks++;
    if (a1 != 26) begin errors++; $display("FAIL ch1_aligned_cycle: got %0d expected 26", a1); end
    checks++;
    if (aa != 27) begin errors++; $display("FAIL allaligned_cycle: got %0d expected 27", aa); end
  endtask

  // ch1 loses lock to 0000, slips four times, then fails; Retrain recovers it.
  task automatic test_chan_fail();
    int p0 = 0, p1 = 0, err_c = 0, ch0_drop = 0;
    SerdesData[7:4] = 4'b0000;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (Bitslip[0] === 1'b1) p0++;
      if (Bitslip[1] === 1'b1) p1++;
      if (ChanError[1] === 1'b1 && err_c == 0) err_c = c;
      if (Aligned[0] !== 1'b1) ch0_drop++;
    end
    checks++;
    if (p1 != 4) begin errors++; $display("FAIL fail_ch1_pulses: got %0d expected 4", p1); end
    checks++;
    if (err_c != 24) begin errors++; $display("FAIL fail_error_cycle: got %0d expected 24", err_c); end
    checks++;
    if (ChanError !== 2'b10 || Aligned !== 2'b01 || AllAligned !== 1'b0) begin
      errors++;
      $display("FAIL fail_state: got err=%b al=%b all=%b expected 10 01 0", ChanError, Aligned, AllAligned);
    end
    checks++;
    if (p0 != 0 || ch0_drop != 0) begin
      errors++; $display("FAIL fail_ch0_untouched: got pulses=%0d drops=%0d expected 0 0", p0, ch0_drop);
    end
    Retrain = 1'b1;
    SerdesData[7:4] = 4'b1010;
    tick();
    Retrain = 1'b0;
    checks++;
    if (ChanError !== 2'b00 || Aligned !== 2'b00) begin
      errors++; $display("FAIL retrain_clear: got err=%b al=%b expected 00 00", ChanError, Aligned);
    end
    tick(); tick(); tick();
    checks++;
    if (Aligned !== 2'b00) begin errors++; $display("FAIL retrain_early: got %b expected 00", Aligned); end
    tick();
    checks++;
    if (Aligned !== 2'b11) begin errors++; $display("FAIL retrain_relock: got %b expected 11", Aligned); end
    tick();
    checks++;
    if (AllAligned !== 1'b1) begin errors++; $display("FAIL retrain_allaligned: got %b expected 1", AllAligned); end
  endtask

  // Two mismatches are tolerated; the third drops lock and slipping restarts from zero.
  task automatic test_loss();
    SerdesData[3:0] = 4'b0000;
    tick(); tick();
    checks++;
    if (Aligned[0] !== 1'b1) begin errors++; $display("FAIL loss_two_miss: got %b expected 1", Aligned[0]); end
    SerdesData[3:0] = 4'b1010;
    tick(); tick();
    checks++;
    if (Aligned[0] !== 1'b1) begin errors++; $display("FAIL loss_recover: got %b expected 1", Aligned[0]); end
    SerdesData[3:0] = 4'b0000;
    tick(); tick();
    checks++;
    if (Aligned[0] !== 1'b1) begin errors++; $display("FAIL loss_before_third: got %b expected 1", Aligned[0]); end
    tick();
    checks++;
    if (Aligned[0] !== 1'b0 || Bitslip[0] !== 1'b0) begin
      errors++; $display("FAIL loss_drop: got al=%b bs=%b expected 0 0", Aligned[0], Bitslip[0]);
    end
    tick();
    checks++;
    if (Bitslip[0] !== 1'b1) begin errors++; $display("FAIL loss_first_slip: got %b expected 1", Bitslip[0]); end
    SerdesData[3:0] = 4'b1010;
    repeat (7) tick();
    checks++;
    if (Aligned[0] !== 1'b0) begin errors++; $display("FAIL loss_relock_early: got %b expected 0", Aligned[0]); end
    tick();
    checks++;
    if (Aligned[0] !== 1'b1) begin errors++; $display("FAIL loss_relock: got %b expected 1", Aligned[0]); end
  endtask

  // Lock drops while ch1 waits after a slip; Retrain arrives as the synchronised lock falls.
  task automatic test_lock_drop();
    int found = 0;
    bit stray = 1'b0;
    SerdesData[7:4] = 4'b0101;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      tick();
      if (Bitslip[1] === 1'b1) found = c;
    end
    checks++;
    if (found != 4) begin errors++; $display("FAIL drop_slip_cycle: got %0d expected 4", found); end
    MmcmLocked = 1'b0;
    tick(); tick();
    checks++;
    if (IoRst !== 1'b0 || IoEna !== 1'b1) begin
      errors++; $display("FAIL drop_sync_latency: got IoRst=%b IoEna=%b expected 0 1", IoRst, IoEna);
    end
    Retrain = 1'b1;
    tick();
    Retrain = 1'b0;
    checks++;
    if ({IoRst, IoEna, Aligned, Bitslip, ChanError} !== 8'b10_00_00_00) begin
      errors++;
      $display("FAIL drop_outputs: got %b expected %b", {IoRst, IoEna, Aligned, Bitslip, ChanError}, 8'b10_00_00_00);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (Bitslip !== 2'b00 || Aligned !== 2'b00 || AllAligned !== 1'b0 || IoRst !== 1'b1) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin errors++; $display("FAIL drop_retrain_ignored: got %b expected 0", stray); end
  endtask

  // Relock, then assert RstN in the middle of VERIFY, between clock edges.
  task automatic test_async_reset();
    int ena_rise = 0;
    logic [8:0] obs;
    SerdesData = {4'b1010, 4'b1010};
    MmcmLocked = 1'b1;
    for (int c = 1; c <= 30 && ena_rise == 0; c++) begin
      tick();
      if (IoEna === 1'b1) ena_rise = c;
    end
    checks++;
    if (ena_rise != 11) begin errors++; $display("FAIL relock_ena_cycle: got %0d expected 11", ena_rise); end
    tick(); tick(); tick();
    checks++;
    if (IoEna !== 1'b1 || IoRst !== 1'b0 || Aligned !== 2'b00) begin
      errors++; $display("FAIL pre_reset_state: got ena=%b rst=%b al=%b expected 1 0 00", IoEna, IoRst, Aligned);
    end
    #1;
    RstN = 1'b0;
    #1;
    obs = {IoRst, IoEna, Bitslip, Aligned, ChanError, AllAligned};
    checks++;
    if (obs !== 9'b1_0_00_00_00_0) begin
      errors++; $display("FAIL async_reset_values: got %b expected %b", obs, 9'b1_0_00_00_00_0);
    end
    tick();
    RstN = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_two_channels();
    test_chan_fail();
    test_loss();
    test_lock_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
